seg_msg_sequencer: RTL and testbench
====================================

// Module: seg_msg_sequencer
// PURPOSE
//   Drives a single 7-segment digit with the fixed message "UNInOrtE", one character at a time.
//   Upstream of the top-level pins: seg_out feeds uo_out[6:0] and dp feeds uo_out[7] in
//   tt_um_uninorte. Control inputs come from ui_in.
//   Modes: free-running scroll with a programmable rate, or manual single-step.
// PARAMETERS
//   PRE_SHIFT  20  char period P = (speed+1) << PRE_SHIFT cycles
//   BLANK_CYC  0   blank (seg_out=0) cycles between characters; 0 = no blank phase
//   CNT_W      24  prescaler width; must hold (8 << PRE_SHIFT) - 1
// PORTS
//   clk      in   1  system clock
//   rst_n    in   1  synchronous active-low reset
//   ena      in   1  global clock-enable; 0 freezes every register
//   run      in   1  1 = auto-scroll, 0 = hold/manual
//   step     in   1  level input; a rising edge advances one char while run=0
//   dir      in   1  0 = forward (idx+1), 1 = reverse (idx-1)
//   speed    in   3  rate select, used in P
//   seg_out  out  7  segments {g,f,e,d,c,b,a}, active-high, registered
//   dp       out  1  decimal point, registered
//   char_idx out  3  current message index, registered
// BEHAVIOUR
//   - Reset state: state=HOLD, idx=0, prescaler=0, step_q=0, seg_out=7'h00, dp=0, char_idx=0.
//   - Character ROM, idx 0..7: 3E 54 06 54 3F 50 78 79 (U n I n O r t E).
//   - seg_out = ROM[idx] in HOLD and SHOW; 7'h00 in BLANK.
//   - seg_out is registered: it updates 1 cycle after idx/state change.
//     The first cycle after reset shows 00, then 3E.
//   - Step edge: step_edge = step & ~step_q; step_q <= step every enabled cycle.
//   - States:
//     - HOLD: prescaler=0.
//       - run=1: go to SHOW.
//       - else, on step_edge: advance idx and stay in HOLD.
//     - SHOW: prescaler++.
//       - At prescaler == P-1: prescaler=0.
//         - BLANK_CYC>0: go to BLANK.
//         - BLANK_CYC=0: advance idx and stay in SHOW.
//     - BLANK: prescaler++.
//       - At prescaler == BLANK_CYC-1: prescaler=0, advance idx, go to SHOW.
//   - run=0 in SHOW or BLANK: go to HOLD next cycle; idx is unchanged and the prescaler clears.
//   - Simultaneous run=1 and step_edge in HOLD: run wins, the step is dropped.
//   - step_edge is ignored while run=1.
//   - Advance wraps: 7 -> 0 forward, 0 -> 7 reverse.
//     dir is sampled at the advance cycle only.
//   - A speed change takes effect at the next compare.
//     If the prescaler is already >= new P-1, it matches at the next wrap of CNT_W. The
//     block instead compares with >=, so the advance occurs on the next cycle.
//   - ena=0: all state, outputs and step_q hold. A step edge that occurs while ena=0 is lost.
//   - rst_n=0 mid-operation: return to the reset state on the next edge, regardless of ena.
//   - char_idx mirrors idx with the same 1-cycle register latency as seg_out.
// CONFIGURATION
//   SEG_DP_HEARTBEAT_EN
//     defined:   dp toggles on every idx advance (auto or manual); reset 0.
//     undefined: dp is tied to 0 and no toggle flop is built.
// TESTING (PRE_SHIFT=2, BLANK_CYC=0 unless stated)
//   1. Reset, run=0, no step for 10 cycles -> seg_out=3E, char_idx=0 steady.
//   2. run=1, dir=0, speed=0 (P=4) -> seg_out walks 3E,54,06,54,3F,50,78,79,3E.
//      Each value lasts 4 cycles; the sequence wraps to idx 0.
//   3. run=0, dir=1, three step pulses -> char_idx 0 -> 7 -> 6 -> 5; seg_out 79, 78, 50.
//      step held high 5 cycles -> exactly one advance.
//   4. BLANK_CYC=2, run=1, speed=1 (P=8) -> 8 cycles of char, then 2 cycles of 00, then next char.
//      Drop run during BLANK -> HOLD, idx unchanged, current char shown.
//   5. ena=0 for 20 cycles mid-SHOW -> outputs frozen; after ena=1, the remaining count resumes.
//      rst_n=0 for 1 cycle mid-SHOW -> seg_out=00, then 3E, char_idx=0.
//   6. SEG_DP_HEARTBEAT_EN defined -> dp toggles on each advance of test 2.
//      Undefined -> dp stays 0.

Source files
------------

// File: rtl/seg_msg_sequencer.sv
// seg_msg_sequencer
//   Shows the fixed message "UNInOrtE" on one 7-segment digit, one character
//   at a time. Either auto-scrolls at a programmable rate or single-steps on
//   rising edges of a step level.
//
//   Parameters
//     PRE_SHIFT  character period P = (speed+1) << PRE_SHIFT cycles
//     BLANK_CYC  blank cycles between characters (0 = no blank phase)
//     CNT_W      prescaler width, must hold (8 << PRE_SHIFT) - 1
//
//   Ports
//     clk       system clock
//     rst_n     synchronous active-low reset (wins over ena)
//     ena       clock enable, 0 freezes every register
//     run       1 = auto-scroll, 0 = hold / manual step
//     step      level input, rising edge advances one char while run=0
//     dir       0 = forward, 1 = reverse
//     speed     rate select
//     seg_out   segments {g,f,e,d,c,b,a}, active-high, registered
//     dp        decimal point, registered
//     char_idx  current message index, registered
//
//   Build option
//     SEG_DP_HEARTBEAT_EN  when defined, dp toggles on every index advance;
//                          otherwise dp is tied to 0.
//
//   state | meaning
//   HOLD  | prescaler cleared; manual stepping, waiting for run
//   SHOW  | character displayed, prescaler counting up to P-1
//   BLANK | digit dark, prescaler counting up to BLANK_CYC-1
module seg_msg_sequencer #(
   parameter int PRE_SHIFT = 20,
   parameter int BLANK_CYC = 0,
   parameter int CNT_W     = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       run,
   input  logic       step,
   input  logic       dir,
   input  logic [2:0] speed,
   output logic [6:0] seg_out,
   output logic       dp,
   output logic [2:0] char_idx
);

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] BLANK_LAST =
      (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] pre_q, pre_d;
   logic             step_q;
   logic [6:0]       seg_q;
   logic [2:0]       cidx_q;
   logic             adv;
   logic             step_edge;
   logic [2:0]       idx_adv;
   logic [CNT_W-1:0] per_last;

   function automatic logic [6:0] char_rom(input logic [2:0] i);
      case (i)
         3'd0:    char_rom = 7'h3E;
         3'd1:    char_rom = 7'h54;
         3'd2:    char_rom = 7'h06;
         3'd3:    char_rom = 7'h54;
         3'd4:    char_rom = 7'h3F;
         3'd5:    char_rom = 7'h50;
         3'd6:    char_rom = 7'h78;
         default: char_rom = 7'h79;
      endcase
   endfunction

   assign step_edge = step & ~step_q;
   assign idx_adv   = dir ? (idx_q - 3'd1) : (idx_q + 3'd1);
   assign per_last  = ((CNT_W'(speed) + CNT_W'(1)) << PRE_SHIFT) - CNT_W'(1);

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      adv     = 1'b0;
      case (state_q)
         ST_HOLD: begin
            pre_d = '0;
            // run has priority: a step edge in the same cycle is dropped
            if (run)
               state_d = ST_SHOW;
            else if (step_edge)
               adv = 1'b1;
         end
         ST_SHOW: begin
            if (!run) begin
               state_d = ST_HOLD;
               pre_d   = '0;
            end else if (pre_q >= per_last) begin
               // >= so a speed drop below the current count advances at once
               pre_d = '0;
               if (BLANK_CYC > 0)
                  state_d = ST_BLANK;
               else
                  adv = 1'b1;
            end else begin
               pre_d = pre_q + CNT_W'(1);
            end
         end
         ST_BLANK: begin
            if (!run) begin
               state_d = ST_HOLD;
               pre_d   = '0;
            end else if (pre_q == BLANK_LAST) begin
               pre_d   = '0;
               adv     = 1'b1;
               state_d = ST_SHOW;
            end else begin
               pre_d = pre_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_HOLD;
            pre_d   = '0;
         end
      endcase
      idx_d = adv ? idx_adv : idx_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_HOLD;
         idx_q   <= 3'd0;
         pre_q   <= '0;
         step_q  <= 1'b0;
         seg_q   <= 7'h00;
         cidx_q  <= 3'd0;
      end else if (ena) begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pre_q   <= pre_d;
         step_q  <= step;
         seg_q   <= (state_q == ST_BLANK) ? 7'h00 : char_rom(idx_q);
         cidx_q  <= idx_q;
      end
   end

`ifdef SEG_DP_HEARTBEAT_EN
   logic dp_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         dp_q <= 1'b0;
      else if (ena && adv)
         dp_q <= ~dp_q;
   end

   assign dp = dp_q;
`else
   assign dp = 1'b0;
`endif

   assign seg_out  = seg_q;
   assign char_idx = cidx_q;

endmodule

// File: tb/tb_seg_msg_sequencer.sv
module tb_seg_msg_sequencer;

   localparam int PS = 2;
   localparam int BB = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       run = 1'b0;
   logic       step = 1'b0;
   logic       dir = 1'b0;
   logic [2:0] speed = 3'd0;
   logic [6:0] seg_a, seg_b;
   logic       dp_a, dp_b;
   logic [2:0] ci_a, ci_b;

   int checks = 0;
   int failures = 0;
   int m_idx_a = 0, m_idx_b = 0, m_adv_a = 0, m_adv_b = 0;

   logic [6:0] rom [8] = '{7'h3E, 7'h54, 7'h06, 7'h54, 7'h3F, 7'h50, 7'h78, 7'h79};

   seg_msg_sequencer #(.PRE_SHIFT(PS), .BLANK_CYC(0), .CNT_W(24)) dut_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .step(step), .dir(dir),
      .speed(speed), .seg_out(seg_a), .dp(dp_a), .char_idx(ci_a));

   seg_msg_sequencer #(.PRE_SHIFT(PS), .BLANK_CYC(BB), .CNT_W(24)) dut_b (
      .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .step(step), .dir(dir),
      .speed(speed), .seg_out(seg_b), .dp(dp_b), .char_idx(ci_b));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int idx_after(input int i0, input bit d, input int n);
      return d ? (((i0 - n) % 8) + 8) % 8 : (i0 + n) % 8;
   endfunction

   // m = number of enabled cycles since scrolling started, before the sample
   function automatic logic [6:0] exp_seg(input int i0, input bit d, input int p,
                                          input int l, input int m);
      if ((m % l) >= p) return 7'h00;
      return rom[idx_after(i0, d, m / l)];
   endfunction

   function automatic logic exp_dp(input int adv);
`ifdef SEG_DP_HEARTBEAT_EN
      return (adv % 2) == 1;
`else
      return (adv < 0);
`endif
   endfunction

   task automatic test_reset;
      rst_n = 1'b0; run = 1'b0; step = 1'b0; ena = 1'b1;
      tick; tick;
      checks++; if (seg_a !== 7'h00) begin failures++; $display("FAIL reset_seg_a got=%h exp=00", seg_a); end
      checks++; if (seg_b !== 7'h00) begin failures++; $display("FAIL reset_seg_b got=%h exp=00", seg_b); end
      checks++; if (ci_a !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", ci_a); end
      checks++; if (dp_a !== 1'b0) begin failures++; $display("FAIL reset_dp got=%b exp=0", dp_a); end
      rst_n = 1'b1;
      checks++; if (seg_a !== 7'h00) begin failures++; $display("FAIL first_cycle_seg got=%h exp=00", seg_a); end
      tick;
      checks++; if (seg_a !== 7'h3E) begin failures++; $display("FAIL post_reset_seg got=%h exp=3e", seg_a); end
      for (int i = 0; i < 10; i++) begin
         tick;
         checks++; if (seg_a !== 7'h3E || ci_a !== 3'd0) begin failures++; $display("FAIL idle_hold got=%h/%0d exp=3e/0", seg_a, ci_a); end
      end
      m_idx_a = 0; m_idx_b = 0; m_adv_a = 0; m_adv_b = 0;
   endtask

   task automatic pulse(input bit d, input int hold);
      dir = d; step = 1'b1;
      tick;
      m_idx_a = idx_after(m_idx_a, d, 1); m_idx_b = idx_after(m_idx_b, d, 1);
      m_adv_a++; m_adv_b++;
      for (int j = 1; j < hold; j++) begin
         dir = 1'($urandom_range(0, 1));
         tick;
      end
      step = 1'b0;
      tick; tick;
      checks++; if (ci_a !== 3'(m_idx_a)) begin failures++; $display("FAIL step_idx_a got=%0d exp=%0d", ci_a, m_idx_a); end
      checks++; if (seg_a !== rom[m_idx_a]) begin failures++; $display("FAIL step_seg_a got=%h exp=%h", seg_a, rom[m_idx_a]); end
      checks++; if (ci_b !== 3'(m_idx_b)) begin failures++; $display("FAIL step_idx_b got=%0d exp=%0d", ci_b, m_idx_b); end
      checks++; if (dp_a !== exp_dp(m_adv_a)) begin failures++; $display("FAIL step_dp got=%b exp=%b", dp_a, exp_dp(m_adv_a)); end
   endtask

   task automatic test_manual_step;
      pulse(1'b1, 1);
      checks++; if (ci_a !== 3'd7 || seg_a !== 7'h79) begin failures++; $display("FAIL rev_wrap got=%0d/%h exp=7/79", ci_a, seg_a); end
      pulse(1'b1, 5);
      checks++; if (ci_a !== 3'd6 || seg_a !== 7'h78) begin failures++; $display("FAIL held_step got=%0d/%h exp=6/78", ci_a, seg_a); end
      pulse(1'b1, 2);
      checks++; if (ci_a !== 3'd5 || seg_a !== 7'h50) begin failures++; $display("FAIL third_step got=%0d/%h exp=5/50", ci_a, seg_a); end
      for (int i = 0; i < 10; i++)
         pulse(1'($urandom_range(0, 1)), int'($urandom_range(1, 5)));
   endtask

   task automatic test_ena_step;
      ena = 1'b0;
      tick;
      step = 1'b1;
      tick; tick;
      step = 1'b0;
      tick;
      ena = 1'b1;
      tick; tick;
      checks++; if (ci_a !== 3'(m_idx_a)) begin failures++; $display("FAIL lost_step_idx got=%0d exp=%0d", ci_a, m_idx_a); end
      checks++; if (seg_a !== rom[m_idx_a]) begin failures++; $display("FAIL lost_step_seg got=%h exp=%h", seg_a, rom[m_idx_a]); end
   endtask

   task automatic scroll(input int spd, input bit d, input int nrun, input int freeze_at);
      int p, lb;
      logic [6:0] hs_a, hs_b;
      logic [2:0] hc_a;
      p  = (spd + 1) << PS;
      lb = p + BB;
      speed = 3'(spd); dir = d; run = 1'b1; step = 1'b1;
      tick;
      for (int k = 1; k <= nrun; k++) begin
         tick;
         checks++; if (seg_a !== exp_seg(m_idx_a, d, p, p, k - 1)) begin failures++; $display("FAIL scroll_seg_a k=%0d got=%h exp=%h", k, seg_a, exp_seg(m_idx_a, d, p, p, k - 1)); end
         checks++; if (ci_a !== 3'(idx_after(m_idx_a, d, (k - 1) / p))) begin failures++; $display("FAIL scroll_idx_a k=%0d got=%0d exp=%0d", k, ci_a, idx_after(m_idx_a, d, (k - 1) / p)); end
         checks++; if (seg_b !== exp_seg(m_idx_b, d, p, lb, k - 1)) begin failures++; $display("FAIL blank_seg_b k=%0d got=%h exp=%h", k, seg_b, exp_seg(m_idx_b, d, p, lb, k - 1)); end
         checks++; if (ci_b !== 3'(idx_after(m_idx_b, d, (k - 1) / lb))) begin failures++; $display("FAIL blank_idx_b k=%0d got=%0d exp=%0d", k, ci_b, idx_after(m_idx_b, d, (k - 1) / lb)); end
         checks++; if (dp_a !== exp_dp(m_adv_a + k / p)) begin failures++; $display("FAIL scroll_dp_a k=%0d got=%b exp=%b", k, dp_a, exp_dp(m_adv_a + k / p)); end
         checks++; if (dp_b !== exp_dp(m_adv_b + k / lb)) begin failures++; $display("FAIL scroll_dp_b k=%0d got=%b exp=%b", k, dp_b, exp_dp(m_adv_b + k / lb)); end
         if (k == 3) step = 1'b0;
         if (k == 5) step = 1'b1;
         if (k == 7) step = 1'b0;
         if (k == freeze_at) begin
            hs_a = seg_a; hs_b = seg_b; hc_a = ci_a;
            ena = 1'b0;
            for (int f = 0; f < 20; f++) begin
               tick;
               checks++; if (seg_a !== hs_a || seg_b !== hs_b || ci_a !== hc_a) begin failures++; $display("FAIL freeze got=%h/%h/%0d exp=%h/%h/%0d", seg_a, seg_b, ci_a, hs_a, hs_b, hc_a); end
            end
            ena = 1'b1;
         end
      end
      run = 1'b0;
      tick;
      checks++; if (seg_a !== exp_seg(m_idx_a, d, p, p, nrun)) begin failures++; $display("FAIL stop_seg_a got=%h exp=%h", seg_a, exp_seg(m_idx_a, d, p, p, nrun)); end
      checks++; if (seg_b !== exp_seg(m_idx_b, d, p, lb, nrun)) begin failures++; $display("FAIL stop_seg_b got=%h exp=%h", seg_b, exp_seg(m_idx_b, d, p, lb, nrun)); end
      m_idx_a = idx_after(m_idx_a, d, nrun / p);  m_adv_a += nrun / p;
      m_idx_b = idx_after(m_idx_b, d, nrun / lb); m_adv_b += nrun / lb;
      tick;
      checks++; if (seg_a !== rom[m_idx_a] || ci_a !== 3'(m_idx_a)) begin failures++; $display("FAIL hold_a got=%h/%0d exp=%h/%0d", seg_a, ci_a, rom[m_idx_a], m_idx_a); end
      checks++; if (seg_b !== rom[m_idx_b] || ci_b !== 3'(m_idx_b)) begin failures++; $display("FAIL hold_b got=%h/%0d exp=%h/%0d", seg_b, ci_b, rom[m_idx_b], m_idx_b); end
   endtask

   task automatic test_scroll;
      scroll(0, 1'b0, 33, -1);
   endtask

   task automatic test_blank_drop;
      // land the run drop inside the blank phase of the BLANK_CYC=2 unit
      scroll(1, 1'($urandom_range(0, 1)), 10 * int'($urandom_range(1, 3)) + 8 + int'($urandom_range(0, 1)), -1);
   endtask

   task automatic test_random_freeze;
      int n;
      for (int i = 0; i < 4; i++) begin
         n = int'($urandom_range(8, 60));
         scroll(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), n, int'($urandom_range(1, n)));
      end
   endtask

   task automatic test_reset_mid;
      speed = 3'd0; dir = 1'b0; run = 1'b1;
      repeat (6) tick;
      rst_n = 1'b0; ena = 1'b0;
      tick;
      checks++; if (seg_a !== 7'h00 || ci_a !== 3'd0) begin failures++; $display("FAIL mid_reset_a got=%h/%0d exp=00/0", seg_a, ci_a); end
      checks++; if (seg_b !== 7'h00 || dp_b !== 1'b0) begin failures++; $display("FAIL mid_reset_b got=%h/%b exp=00/0", seg_b, dp_b); end
      rst_n = 1'b1; ena = 1'b1; run = 1'b0;
      tick;
      checks++; if (seg_a !== 7'h3E || ci_a !== 3'd0) begin failures++; $display("FAIL after_reset got=%h/%0d exp=3e/0", seg_a, ci_a); end
      m_idx_a = 0; m_idx_b = 0; m_adv_a = 0; m_adv_b = 0;
   endtask

   task automatic test_speed_change;
      int ia, ib;
      ia = m_idx_a; ib = m_idx_b;
      dir = 1'b0; speed = 3'd7; run = 1'b1;
      tick;
      repeat (20) tick;
      speed = 3'd0;
      tick;
      checks++; if (ci_a !== 3'(ia)) begin failures++; $display("FAIL spd_drop_e21 got=%0d exp=%0d", ci_a, ia); end
      tick;
      checks++; if (ci_a !== 3'((ia + 1) % 8) || seg_a !== rom[(ia + 1) % 8]) begin failures++; $display("FAIL spd_drop_adv got=%0d/%h exp=%0d", ci_a, seg_a, (ia + 1) % 8); end
      checks++; if (seg_b !== 7'h00 || ci_b !== 3'(ib)) begin failures++; $display("FAIL spd_drop_blank got=%h/%0d exp=00/%0d", seg_b, ci_b, ib); end
      repeat (3) tick;
      checks++; if (ci_a !== 3'((ia + 1) % 8)) begin failures++; $display("FAIL spd_new_p_e25 got=%0d exp=%0d", ci_a, (ia + 1) % 8); end
      tick;
      checks++; if (ci_a !== 3'((ia + 2) % 8)) begin failures++; $display("FAIL spd_new_p_e26 got=%0d exp=%0d", ci_a, (ia + 2) % 8); end
      checks++; if (ci_b !== 3'((ib + 1) % 8) || seg_b !== rom[(ib + 1) % 8]) begin failures++; $display("FAIL spd_drop_b got=%0d/%h exp=%0d", ci_b, seg_b, (ib + 1) % 8); end
      run = 1'b0;
      tick; tick;
      test_reset_mid;
      // speed raised while the count is still below the new limit
      speed = 3'd0; run = 1'b1;
      tick; tick; tick;
      speed = 3'd3;
      repeat (14) tick;
      checks++; if (ci_a !== 3'd0) begin failures++; $display("FAIL spd_up_e16 got=%0d exp=0", ci_a); end
      tick;
      checks++; if (ci_a !== 3'd1 || seg_a !== 7'h54) begin failures++; $display("FAIL spd_up_e17 got=%0d/%h exp=1/54", ci_a, seg_a); end
      checks++; if (seg_b !== 7'h00 || ci_b !== 3'd0) begin failures++; $display("FAIL spd_up_b got=%h/%0d exp=00/0", seg_b, ci_b); end
      run = 1'b0;
      tick; tick;
      test_reset_mid;
   endtask

   initial begin
      test_reset;
      test_manual_step;
      test_ena_step;
      test_scroll;
      test_blank_drop;
      test_random_freeze;
      test_speed_change;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
